shift_xfer_ctrl: RTL and testbench
==================================

# shift_xfer_ctrl

Transfer controller for the 4-bit bidirectional shift-register datapath. It accepts a parallel word over a valid/ready handshake, loads it into an internal 4-bit shift register, and shifts it out serially for exactly four shift ticks in a per-transfer direction. The bits captured from `serial_in` during those ticks are returned as a parallel word over a second valid/ready handshake. It sits between a parallel host (e.g. the top-level `ui_in`/`uo_out` pin mapping) and a serial line.

## Interface
Parameters:
- `CLK_DIV`, default 1: clk cycles per shift tick, legal range 1..255. A value of 0 is illegal and must be caught by an elaboration assertion.

Ports (reset is asynchronous and active-high; clock is `clk`):
- `clk` — input, 1 bit: clock, rising edge.
- `reset` — input, 1 bit: asynchronous, active-high reset.
- `tx_data` — input, 4 bits: word to send.
- `tx_dir` — input, 1 bit: shift direction, 0 = right (LSB first), 1 = left (MSB first).
- `tx_valid` — input, 1 bit: `tx_data` and `tx_dir` are valid.
- `tx_ready` — output, 1 bit: controller can accept a word.
- `serial_in` — input, 1 bit: incoming serial bit, sampled at each shift tick.
- `serial_out` — output, 1 bit: outgoing serial bit.
- `rx_data` — output, 4 bits: received word.
- `rx_valid` — output, 1 bit: `rx_data` is valid.
- `rx_ready` — input, 1 bit: consumer accepts `rx_data`.
- `busy` — output, 1 bit: a transfer is in progress (state is not IDLE).

## Operation
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: `tx_ready`=1. On `tx_valid & tx_ready`, load the register with `tx_data` (sub-module `load`=1 for that edge), latch `tx_dir`, clear the tick counter and the bit counter, and go to SHIFT.
  - SHIFT: the tick counter counts 0..CLK_DIV-1. When it reaches CLK_DIV-1, issue one shift and increment the bit counter (0..3).
    - Right shift: q <= {serial_in, q[3:1]}.
    - Left shift: q <= {q[2:0], serial_in}.
    - After the 4th shift, go to DONE.
  - DONE: `rx_valid`=1 and `rx_data`=q, held stable. On `rx_valid & rx_ready`, go to IDLE.
- `serial_out` is purely combinational from the register: q[0] when the latched direction is right, q[3] when it is left. It is q[0] in IDLE.
- `tx_ready` = (state==IDLE), driven from registered state only, with no combinational path from `tx_valid`.
- `rx_data` = q in every state. It is meaningful only while `rx_valid`=1.
- `tx_data` and `tx_dir` are ignored whenever `tx_ready`=0. A change to `tx_dir` mid-transfer has no effect.
- Received word:
  - Right shift: the register ends as {s4,s3,s2,s1}, where s1 is the first bit sampled.
  - Left shift: the register ends as {s1,s2,s3,s4}.
- Reset, including reset mid-transfer:
  - state=IDLE, q=0, both counters 0, latched direction=0.
  - Outputs after reset: `tx_ready`=1, `rx_valid`=0, `busy`=0, `serial_out`=0, `rx_data`=0.
  - An aborted transfer never produces `rx_valid`.

## Timing
- Let E be the accept edge. Shift k (k=1..4) happens at edge E+k·CLK_DIV.
- `serial_out` bit k is stable during the cycles between the shift edges, i.e. in the window before edge E+k·CLK_DIV.
- `serial_in` is sampled only at shift edges.
- `rx_valid` rises in the cycle after edge E+4·CLK_DIV. Latency from accept to `rx_valid` is 4·CLK_DIV cycles.
- If `rx_ready`=1 while in DONE, DONE lasts exactly 1 cycle, then 1 cycle of IDLE follows before the next accept. Minimum accept-to-accept period is 4·CLK_DIV+2 cycles.
- `rx_ready` held low stalls in DONE indefinitely. `rx_data` stays constant and `tx_ready` stays 0.
- `rx_ready` asserted outside DONE has no effect.
- All outputs are registered state or a combinational function of registered state. There is no input-to-output combinational path.

## Structure
- Shared package `shift_pkg`:
  - `SR_WIDTH`=4.
  - Direction constants `DIR_RIGHT`=1'b0 and `DIR_LEFT`=1'b1.
  - FSM state enum `xfer_state_t` {IDLE, SHIFT, DONE}.
- Sub-module `shift_reg4`: the 4-bit load/shift register, with inputs clk, reset, load, shift_en, direction, serial_in, parallel_in[3:0] and output q[3:0].
  - Priority: reset > load > shift_en > hold.
  - The controller instantiates exactly one `shift_reg4`.
- Tick counter width is 8 bits. Bit counter width is 2 bits; it wraps 3→0 on the 4th shift.

## Test plan
- Right shift, CLK_DIV=1: `tx_data`=4'b1011, `tx_dir`=0, `serial_in`=1,0,0,1 → `serial_out`=1,1,0,1; `rx_data`=4'b1001; `rx_valid` rises 4 cycles after the accept.
- Left shift, CLK_DIV=3: `tx_data`=4'b1011, `tx_dir`=1, `serial_in`=1,1,0,0 → `serial_out`=1,0,1,1, each bit held 3 cycles; `rx_data`=4'b1100 after 12 cycles.
- Backpressure: `rx_ready`=0 for 10 cycles in DONE → `rx_valid` and `rx_data` stay stable and `tx_ready`=0; pulse `rx_ready` → IDLE next cycle; a back-to-back transfer gives an accept-to-accept period of exactly 6 cycles (CLK_DIV=1).
- Input ignoring: toggle `tx_valid`, `tx_data` and `tx_dir` during SHIFT → no second accept, and the first transfer's output sequence is unchanged.
- Reset after the 2nd shift → next cycle: `tx_ready`=1, `busy`=0, `rx_valid`=0 and stays 0, `rx_data`=0; a fresh transfer of 4'b0110 right then completes correctly.
- Elaboration with CLK_DIV=0 → assertion fires.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared definitions for the 4-bit shift-register transfer path.
//   SR_WIDTH      : shift register width
//   DIR_RIGHT/LEFT: direction encoding (right = LSB first, left = MSB first)
//   xfer_state_t  : transfer controller FSM states
package shift_pkg;
  localparam int   SR_WIDTH  = 4;
  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } xfer_state_t;
endpackage

// File: rtl/shift_reg4.sv
// 4-bit bidirectional load/shift register.
// Priority: reset > load > shift_en > hold.
//   clk, reset   : clock, async active-high reset (clears q)
//   load         : capture parallel_in
//   shift_en     : shift one position, filling with serial_in
//   direction    : DIR_RIGHT -> q <= {serial_in, q[3:1]}; DIR_LEFT -> q <= {q[2:0], serial_in}
//   parallel_in  : word to load
//   q            : register contents
module shift_reg4
  import shift_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic                shift_en,
  input  logic                direction,
  input  logic                serial_in,
  input  logic [SR_WIDTH-1:0] parallel_in,
  output logic [SR_WIDTH-1:0] q
);

  logic [SR_WIDTH-1:0] r_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_q <= '0;
    else if (load)
      r_q <= parallel_in;
    else if (shift_en) begin
      if (direction == DIR_LEFT)
        r_q <= {r_q[SR_WIDTH-2:0], serial_in};
      else
        r_q <= {serial_in, r_q[SR_WIDTH-1:1]};
    end
  end

  assign q = r_q;

endmodule

// File: rtl/shift_xfer_ctrl.sv
// Transfer controller: accepts a parallel word (valid/ready), shifts it out
// serially over exactly four shift ticks in the latched direction while
// capturing serial_in, and returns the captured word (valid/ready).
//   CLK_DIV    : clk cycles per shift tick (1..255)
//   clk, reset : clock, async active-high reset
//   tx_data/tx_dir/tx_valid/tx_ready : parallel input handshake
//   serial_in/serial_out             : serial line
//   rx_data/rx_valid/rx_ready        : parallel output handshake
//   busy       : state is not IDLE
module shift_xfer_ctrl
  import shift_pkg::*;
#(
  parameter int CLK_DIV = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SR_WIDTH-1:0] tx_data,
  input  logic                tx_dir,
  input  logic                tx_valid,
  output logic                tx_ready,
  input  logic                serial_in,
  output logic                serial_out,
  output logic [SR_WIDTH-1:0] rx_data,
  output logic                rx_valid,
  input  logic                rx_ready,
  output logic                busy
);

  if (CLK_DIV < 1 || CLK_DIV > 255) begin : g_bad_clk_div
    $fatal(1, "shift_xfer_ctrl: CLK_DIV=%0d outside legal range 1..255", CLK_DIV);
  end

  localparam logic [7:0] TICK_LAST = 8'(CLK_DIV - 1);

  xfer_state_t         r_state;
  xfer_state_t         w_state_nxt;
  logic [7:0]          r_tick;
  logic [1:0]          r_bit;
  logic                r_dir;
  logic                w_load;
  logic                w_shift;
  logic [SR_WIDTH-1:0] w_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    case (r_state)
      IDLE: begin
        if (tx_valid) begin
          w_load      = 1'b1;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (r_tick == TICK_LAST) begin
          w_shift = 1'b1;
          // Bit counter sits at 3 during the fourth shift; it wraps to 0.
          if (r_bit == 2'd3) w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (rx_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Tick/bit counters and latched direction; direction is frozen for the
  // whole transfer so mid-transfer tx_dir changes are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tick <= '0;
      r_bit  <= '0;
      r_dir  <= DIR_RIGHT;
    end else if (w_load) begin
      r_tick <= '0;
      r_bit  <= '0;
      r_dir  <= tx_dir;
    end else if (r_state == SHIFT) begin
      if (w_shift) begin
        r_tick <= '0;
        r_bit  <= r_bit + 2'd1;
      end else begin
        r_tick <= r_tick + 8'd1;
      end
    end
  end

  shift_reg4 u_sr (
    .clk        (clk),
    .reset      (reset),
    .load       (w_load),
    .shift_en   (w_shift),
    .direction  (r_dir),
    .serial_in  (serial_in),
    .parallel_in(tx_data),
    .q          (w_q)
  );

  assign tx_ready   = (r_state == IDLE);
  assign busy       = (r_state != IDLE);
  assign rx_valid   = (r_state == DONE);
  assign rx_data    = w_q;
  // IDLE always presents q[0] regardless of the last transfer's direction.
  assign serial_out = (r_state != IDLE && r_dir == DIR_LEFT) ? w_q[SR_WIDTH-1] : w_q[0];

endmodule

// File: tb/tb_shift_xfer_ctrl.sv
// Bench for shift_xfer_ctrl: two instances (CLK_DIV=1 and CLK_DIV=3) driven
// one at a time; expected rx words queued at accept, popped at rx_valid.
module tb_shift_xfer_ctrl;
  logic            clk = 1'b0;
  logic            reset;
  logic [1:0][3:0] tx_data, rx_data;
  logic [1:0]      tx_dir, tx_valid, tx_ready, serial_in, serial_out;
  logic [1:0]      rx_valid, rx_ready, busy;

  int         n_chk = 0, n_fail = 0;
  int         cyc = 0;
  int         last_acc [2];
  logic [3:0] sb_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  shift_xfer_ctrl #(.CLK_DIV(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .tx_data(tx_data[0]), .tx_dir(tx_dir[0]), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]),
    .serial_in(serial_in[0]), .serial_out(serial_out[0]),
    .rx_data(rx_data[0]), .rx_valid(rx_valid[0]), .rx_ready(rx_ready[0]), .busy(busy[0])
  );

  shift_xfer_ctrl #(.CLK_DIV(3)) u_dut3 (
    .clk(clk), .reset(reset),
    .tx_data(tx_data[1]), .tx_dir(tx_dir[1]), .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]),
    .serial_in(serial_in[1]), .serial_out(serial_out[1]),
    .rx_data(rx_data[1]), .rx_valid(rx_valid[1]), .rx_ready(rx_ready[1]), .busy(busy[1])
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // One full transfer on instance d. sin[k] is the bit presented before shift k+1.
  // Called and returns at a negedge.
  task automatic xfer(input int d, input logic [3:0] data, input logic dir,
                      input logic [3:0] sin, input int stall, input bit noise, input bit b2b);
    int         div, n, acc;
    logic [3:0] q, out, exp_rx;
    div = (d == 0) ? 1 : 3;
    n   = 0;
    acc = 0;
    while (tx_ready[d] !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("tx_ready_idle", tx_ready[d], 1);

    q = data;
    for (int k = 0; k < 4; k++) begin
      out[k] = dir ? q[3] : q[0];
      q      = dir ? {q[2:0], sin[k]} : {sin[k], q[3:1]};
    end
    sb_q.push_back(q);

    tx_data[d]  = data;
    tx_dir[d]   = dir;
    tx_valid[d] = 1'b1;
    rx_ready[d] = 1'b0;
    @(posedge clk);

    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < div; c++) begin
        @(negedge clk);
        if (k == 0 && c == 0) acc = cyc;
        tx_valid[d]  = 1'b0;
        rx_ready[d]  = 1'b0;
        serial_in[d] = sin[k];
        if (noise && !(k == 3 && c == div - 1)) begin
          tx_valid[d] = 1'($urandom);
          tx_data[d]  = 4'($urandom);
          tx_dir[d]   = 1'($urandom);
          rx_ready[d] = 1'($urandom);
        end
        chk("serial_out", serial_out[d], out[k]);
        chk("busy_shift", busy[d], 1);
        chk("rx_valid_shift", rx_valid[d], 0);
      end
    end

    @(negedge clk);
    chk("latency", cyc - acc, 4 * div);
    chk("rx_valid", rx_valid[d], 1);
    chk("tx_ready_done", tx_ready[d], 0);
    exp_rx = 4'h0;
    if (sb_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard: rx_valid seen with no expected word queued");
    end else begin
      exp_rx = sb_q.pop_front();
      chk("rx_data", rx_data[d], exp_rx);
    end
    if (b2b) chk("period", acc - last_acc[d], 4 * div + 2);
    last_acc[d] = acc;

    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("stall_rx_valid", rx_valid[d], 1);
      chk("stall_rx_data", rx_data[d], exp_rx);
      chk("stall_tx_ready", tx_ready[d], 0);
    end
    rx_ready[d] = 1'b1;
    @(negedge clk);
    rx_ready[d] = 1'b0;
    chk("idle_tx_ready", tx_ready[d], 1);
    chk("idle_busy", busy[d], 0);
    chk("idle_rx_valid", rx_valid[d], 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    tx_data   = '0;
    tx_dir    = '0;
    tx_valid  = '0;
    serial_in = '0;
    rx_ready  = '0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_tx_ready", tx_ready[d], 1);
      chk("rst_rx_valid", rx_valid[d], 0);
      chk("rst_busy", busy[d], 0);
      chk("rst_serial_out", serial_out[d], 0);
      chk("rst_rx_data", rx_data[d], 0);
    end
    reset = 1'b0;
    @(negedge clk);

    // Right, CLK_DIV=1: serial_in 1,0,0,1 -> rx 1001
    xfer(0, 4'b1011, 1'b0, 4'b1001, 0, 1'b0, 1'b0);
    // Left, CLK_DIV=3: serial_in 1,1,0,0 -> rx 1100
    xfer(1, 4'b1011, 1'b1, 4'b0011, 0, 1'b0, 1'b0);
    // Backpressure, then a back-to-back pair for the 6-cycle period
    xfer(0, 4'b0101, 1'b0, 4'b0110, 10, 1'b0, 1'b0);
    xfer(0, 4'b1100, 1'b1, 4'b1010, 0, 1'b0, 1'b0);
    xfer(0, 4'b0011, 1'b0, 4'b0111, 0, 1'b0, 1'b1);
    xfer(1, 4'b1001, 1'b0, 4'b1100, 0, 1'b0, 1'b0);
    xfer(1, 4'b0110, 1'b1, 4'b0101, 0, 1'b0, 1'b1);
    // Input noise during SHIFT must not disturb the transfer
    xfer(0, 4'b1110, 1'b0, 4'b0100, 0, 1'b1, 1'b0);
    xfer(1, 4'b0001, 1'b1, 4'b1101, 2, 1'b1, 1'b0);

    // Reset after the second shift (CLK_DIV=1)
    tx_data[0]   = 4'b1010;
    tx_dir[0]    = 1'b1;
    tx_valid[0]  = 1'b1;
    serial_in[0] = 1'b1;
    @(posedge clk);
    repeat (3) begin
      @(negedge clk);
      tx_valid[0] = 1'b0;
    end
    chk("pre_reset_busy", busy[0], 1);
    reset = 1'b1;
    #1;
    chk("async_rst_tx_ready", tx_ready[0], 1);
    chk("async_rst_busy", busy[0], 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("post_rst_rx_valid", rx_valid[0], 0);
      chk("post_rst_tx_ready", tx_ready[0], 1);
      chk("post_rst_busy", busy[0], 0);
      chk("post_rst_rx_data", rx_data[0], 0);
      chk("post_rst_serial_out", serial_out[0], 0);
    end
    xfer(0, 4'b0110, 1'b0, 4'b1011, 0, 1'b0, 1'b0);

    // Random transfers on either instance
    for (int i = 0; i < 8; i++) begin
      xfer(int'($urandom_range(0, 1)), 4'($urandom), 1'($urandom), 4'($urandom),
           int'($urandom_range(0, 3)), 1'b1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
